// File: rtl/vga_pkg.sv
// Shared types and pixel-format helpers for the framebuffer fetch engine.
package vga_pkg;

   // Framebuffer pixel formats selectable through fb_mode.
   typedef enum logic {
      FB_MODE_XRGB8888 = 1'b0,
      FB_MODE_RGB565   = 1'b1
   } fb_mode_t;

   // Sideband travelling alongside a BRAM read until its data returns.
   typedef struct packed {
      logic     active;
      logic     fetched;
      logic     half;
      fb_mode_t mode;
   } fb_pipe_entry_t;

   // Expand RGB565 to RGB888 by replicating the MSBs into the vacated LSBs.
   function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] p);
      return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
   endfunction

endpackage

// File: rtl/vga_fb_pipe.sv
// Fixed-depth shift register carrying per-pixel sideband, matched to BRAM read latency.
module vga_fb_pipe
   import vga_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic           vga_clk,
   input  logic           vga_rst_n,
   input  fb_pipe_entry_t in_entry,
   output fb_pipe_entry_t out_entry
);

   fb_pipe_entry_t stage_q [DEPTH];

   // Shift entries one stage per clock; async reset flushes every stage.
   always_ff @(posedge vga_clk or negedge vga_rst_n) begin
      if (!vga_rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= in_entry;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign out_entry = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_fb_fetch.sv
// Framebuffer fetch engine: maps VGA coordinates to BRAM word reads with
// pixel replication, 32/16 bpp formats, redundant-read suppression and
// frame-synchronous shadowing of base/format/enable.
module vga_fb_fetch
   import vga_pkg::*;
#(
   parameter int unsigned SRC_W      = 400,
   parameter int unsigned SRC_H      = 300,
   parameter int unsigned SCALE_LOG2 = 0,
   parameter int unsigned RD_LAT     = 1
) (
   input  logic        vga_clk,
   input  logic        vga_rst_n,
   input  logic [31:0] fb_base,
   input  logic        fb_mode,
   input  logic        fb_enable,
   input  logic [9:0]  vga_h_addr,
   input  logic [9:0]  vga_v_addr,
   output logic [31:0] vga_data,
   output logic        vga_valid,
   output logic        bram_clk,
   output logic        bram_rst,
   output logic        bram_en,
   output logic [3:0]  bram_we,
   output logic [31:0] bram_din,
   output logic [31:0] bram_addr,
   input  logic [31:0] bram_dout
);

   localparam logic [31:0] SRC_W32 = 32'(SRC_W);
   localparam logic [31:0] ACT_W   = 32'(SRC_W << SCALE_LOG2);
   localparam logic [31:0] ACT_H   = 32'(SRC_H << SCALE_LOG2);

   logic [31:0]    base_q;
   fb_mode_t       mode_q;
   logic           en_q;
   logic [31:0]    last_widx;
   logic           last_vld;
   logic [31:0]    word_q;

   logic           load;
   logic [31:0]    eff_base;
   fb_mode_t       eff_mode;
   logic           eff_en;
   logic [31:0]    h32;
   logic [31:0]    v32;
   logic [31:0]    sx;
   logic [31:0]    sy;
   logic [31:0]    pix;
   logic [31:0]    widx;
   logic           half;
   logic           active;
   logic           eff_last_vld;
   fb_pipe_entry_t pipe_in;
   fb_pipe_entry_t pipe_out;
   logic [31:0]    word_sel;
   logic [15:0]    p565;

   assign bram_clk = vga_clk;
   assign bram_rst = ~vga_rst_n;
   assign bram_we  = '0;
   assign bram_din = '0;

   // Shadow values bypass to the current pixel so (0,0) already uses them.
   always_comb begin
      load     = (vga_h_addr == '0) && (vga_v_addr == '0);
      eff_base = load ? fb_base : base_q;
      eff_mode = load ? fb_mode_t'(fb_mode) : mode_q;
      eff_en   = load ? fb_enable : en_q;
   end

   // Coordinate-to-address mapping and fetch decision.
   always_comb begin
      h32          = {22'd0, vga_h_addr};
      v32          = {22'd0, vga_v_addr};
      sx           = h32 >> SCALE_LOG2;
      sy           = v32 >> SCALE_LOG2;
      pix          = 32'(sy * SRC_W32) + sx;
      widx         = (eff_mode == FB_MODE_RGB565) ? (pix >> 1) : pix;
      half         = (eff_mode == FB_MODE_RGB565) ? pix[0] : 1'b0;
      active       = (h32 < ACT_W) && (v32 < ACT_H) && eff_en;
      // A shadow load may change base/format, so never reuse across it.
      eff_last_vld = last_vld && !load;
      bram_en      = active && !(eff_last_vld && (widx == last_widx));
      bram_addr    = eff_base + {widx[29:0], 2'b00};
   end

   // Shadow registers, loaded at every frame origin.
   always_ff @(posedge vga_clk or negedge vga_rst_n) begin
      if (!vga_rst_n) begin
         base_q <= '0;
         mode_q <= FB_MODE_XRGB8888;
         en_q   <= 1'b0;
      end else if (load) begin
         base_q <= fb_base;
         mode_q <= fb_mode_t'(fb_mode);
         en_q   <= fb_enable;
      end
   end

   // Remember the last fetched word to suppress repeat reads.
   always_ff @(posedge vga_clk or negedge vga_rst_n) begin
      if (!vga_rst_n) begin
         last_widx <= '0;
         last_vld  <= 1'b0;
      end else if (bram_en) begin
         last_widx <= widx;
         last_vld  <= 1'b1;
      end else if (load || !active) begin
         last_vld  <= 1'b0;
      end
   end

   // Package the sideband for this pixel.
   always_comb begin
      pipe_in         = '0;
      pipe_in.active  = active;
      pipe_in.fetched = bram_en;
      pipe_in.half    = half;
      pipe_in.mode    = eff_mode;
   end

   vga_fb_pipe #(
      .DEPTH(RD_LAT)
   ) u_pipe (
      .vga_clk  (vga_clk),
      .vga_rst_n(vga_rst_n),
      .in_entry (pipe_in),
      .out_entry(pipe_out)
   );

   // Hold the most recent returned word for pixels that reuse it.
   always_ff @(posedge vga_clk or negedge vga_rst_n) begin
      if (!vga_rst_n) begin
         word_q <= '0;
      end else if (pipe_out.active && pipe_out.fetched) begin
         word_q <= bram_dout;
      end
   end

   // Format the output pixel; the select is from the BRAM output register or word_q.
   always_comb begin
      word_sel  = pipe_out.fetched ? bram_dout : word_q;
      p565      = pipe_out.half ? word_sel[31:16] : word_sel[15:0];
      vga_valid = pipe_out.active;
      vga_data  = '0;
      if (pipe_out.active) begin
         if (pipe_out.mode == FB_MODE_RGB565) begin
            vga_data = {8'h00, rgb565_to_rgb888(p565)};
         end else begin
            vga_data = {8'h00, word_sel[23:0]};
         end
      end
   end

endmodule

// File: tb/tb_vga_fb_fetch.sv
// Directed self-checking bench for vga_fb_fetch: three instances cover
// scale 1x/latency 1, scale 2x/latency 1 and scale 1x/latency 2.
module tb_vga_fb_fetch;

   logic        clk;
   logic        rst_n;
   logic [31:0] fb_base;
   logic        fb_mode;
   logic        fb_enable;
   logic [9:0]  h;
   logic [9:0]  v;
   logic [31:0] word0_val;

   logic [31:0] data0, data1, data2;
   logic        valid0, valid1, valid2;
   logic        bclk0, bclk1, bclk2;
   logic        brst0, brst1, brst2;
   logic        en0, en1, en2;
   logic [3:0]  we0, we1, we2;
   logic [31:0] din0, din1, din2;
   logic [31:0] addr0, addr1, addr2;
   logic [31:0] dout0, dout1, dout2, d2a;

   int n_cmp = 0;
   int n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vga_fb_fetch #(.SRC_W(400), .SRC_H(300), .SCALE_LOG2(0), .RD_LAT(1)) u0 (
      .vga_clk(clk), .vga_rst_n(rst_n), .fb_base(fb_base), .fb_mode(fb_mode),
      .fb_enable(fb_enable), .vga_h_addr(h), .vga_v_addr(v), .vga_data(data0),
      .vga_valid(valid0), .bram_clk(bclk0), .bram_rst(brst0), .bram_en(en0),
      .bram_we(we0), .bram_din(din0), .bram_addr(addr0), .bram_dout(dout0));

   vga_fb_fetch #(.SRC_W(400), .SRC_H(300), .SCALE_LOG2(1), .RD_LAT(1)) u1 (
      .vga_clk(clk), .vga_rst_n(rst_n), .fb_base(fb_base), .fb_mode(fb_mode),
      .fb_enable(fb_enable), .vga_h_addr(h), .vga_v_addr(v), .vga_data(data1),
      .vga_valid(valid1), .bram_clk(bclk1), .bram_rst(brst1), .bram_en(en1),
      .bram_we(we1), .bram_din(din1), .bram_addr(addr1), .bram_dout(dout1));

   vga_fb_fetch #(.SRC_W(400), .SRC_H(300), .SCALE_LOG2(0), .RD_LAT(2)) u2 (
      .vga_clk(clk), .vga_rst_n(rst_n), .fb_base(fb_base), .fb_mode(fb_mode),
      .fb_enable(fb_enable), .vga_h_addr(h), .vga_v_addr(v), .vga_data(data2),
      .vga_valid(valid2), .bram_clk(bclk2), .bram_rst(brst2), .bram_en(en2),
      .bram_we(we2), .bram_din(din2), .bram_addr(addr2), .bram_dout(dout2));

   // Memory image: word k at 0x1000 + 4k holds k, except word 0.
   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (a == 32'h0000_1000) return word0_val;
      return (a - 32'h0000_1000) >> 2;
   endfunction

   always @(posedge clk) if (en0) dout0 <= mem_rd(addr0);
   always @(posedge clk) if (en1) dout1 <= mem_rd(addr1);
   always @(posedge clk) begin
      if (en2) d2a <= mem_rd(addr2);
      dout2 <= d2a;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic set_xy(input int x, input int y);
      h = 10'(x);
      v = 10'(y);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      fb_base   = 32'h0000_1000;
      fb_mode   = 1'b0;
      fb_enable = 1'b1;
      word0_val = 32'hF800_001F;
      h         = 10'd5;
      v         = 10'd5;
      #12;
      chk("rst_data0", data0, 32'h0);
      chk("rst_valid0", {31'd0, valid0}, 32'h0);
      chk("rst_en0", {31'd0, en0}, 32'h0);
      chk("rst_valid2", {31'd0, valid2}, 32'h0);
      chk("bram_rst", {29'd0, brst0, brst1, brst2}, 32'h7);
      chk("bram_clk", {30'd0, bclk0 ^ clk, bclk1 ^ bclk2}, 32'h0);
      chk("bram_we", {20'd0, we0, we1, we2}, 32'h0);
      chk("bram_din", din0 | din1 | din2, 32'h0);
      tick();
      rst_n = 1'b1;

      // Mode 0, 1x, latency 1
      set_xy(0, 0);
      chk("m0_en_00", {31'd0, en0}, 32'h1);
      chk("m0_addr_00", addr0, 32'h0000_1000);
      tick();
      chk("m0_data_00", data0, 32'h0000_001F);
      chk("m0_valid_00", {31'd0, valid0}, 32'h1);
      set_xy(5, 2);
      chk("m0_en_52", {31'd0, en0}, 32'h1);
      chk("m0_addr_52", addr0, 32'h0000_1C94);
      tick();
      chk("m0_data_52", data0, 32'h0000_0325);
      chk("m0_valid_52", {31'd0, valid0}, 32'h1);
      set_xy(400, 0);
      chk("oor_en", {31'd0, en0}, 32'h0);
      tick();
      chk("oor_data", data0, 32'h0);
      chk("oor_valid", {31'd0, valid0}, 32'h0);

      // Mode 1 (RGB565)
      fb_mode = 1'b1;
      set_xy(0, 0);
      chk("m1_en_h0", {31'd0, en0}, 32'h1);
      chk("m1_addr_h0", addr0, 32'h0000_1000);
      tick();
      chk("m1_data_h0", data0, 32'h0000_00FF);
      set_xy(1, 0);
      chk("m1_en_h1", {31'd0, en0}, 32'h0);
      tick();
      chk("m1_data_h1", data0, 32'h00FF_0000);
      chk("m1_valid_h1", {31'd0, valid0}, 32'h1);
      set_xy(2, 0);
      chk("m1_en_h2", {31'd0, en0}, 32'h1);
      chk("m1_addr_h2", addr0, 32'h0000_1004);
      tick();
      chk("m1_data_h2", data0, 32'h0000_0008);

      // 2x replication on u1, mode 0
      fb_mode = 1'b0;
      for (int y = 0; y < 2; y++) begin
         for (int x = 0; x < 4; x++) begin
            set_xy(x, y);
            chk($sformatf("sc_en_%0d_%0d", x, y), {31'd0, en1}, (x % 2 == 0) ? 32'h1 : 32'h0);
            if (x % 2 == 0)
               chk($sformatf("sc_addr_%0d_%0d", x, y), addr1, (x == 0) ? 32'h0000_1000 : 32'h0000_1004);
            tick();
            chk($sformatf("sc_data_%0d_%0d", x, y), data1, (x < 2) ? 32'h0000_001F : 32'h0000_0001);
            chk($sformatf("sc_valid_%0d_%0d", x, y), {31'd0, valid1}, 32'h1);
         end
      end

      // Shadow load of base
      fb_base = 32'h0000_2000;
      set_xy(5, 2);
      chk("sh_addr_mid", addr0, 32'h0000_1C94);
      tick();
      set_xy(0, 0);
      chk("sh_addr_00", addr0, 32'h0000_2000);
      chk("sh_en_00", {31'd0, en0}, 32'h1);
      tick();
      set_xy(1, 0);
      chk("sh_addr_10", addr0, 32'h0000_2004);
      tick();

      // Disabled frame
      fb_enable = 1'b0;
      set_xy(0, 0);
      chk("dis_en_00", {31'd0, en0}, 32'h0);
      tick();
      chk("dis_valid_00", {31'd0, valid0}, 32'h0);
      chk("dis_data_00", data0, 32'h0);
      fb_enable = 1'b1;
      set_xy(5, 2);
      chk("dis_en_52", {31'd0, en0}, 32'h0);
      tick();
      chk("dis_valid_52", {31'd0, valid0}, 32'h0);

      // Address wrap at maximum base, last pixel
      fb_base = 32'hFFFF_FFFC;
      set_xy(0, 0);
      chk("wrap_addr_00", addr0, 32'hFFFF_FFFC);
      tick();
      set_xy(399, 299);
      chk("wrap_en", {31'd0, en0}, 32'h1);
      chk("wrap_addr", addr0, 32'h0007_52F8);
      tick();
      chk("wrap_valid", {31'd0, valid0}, 32'h1);

      // Latency 2 with async reset mid-line
      fb_base = 32'h0000_1000;
      set_xy(0, 0);
      tick();
      set_xy(1, 0);
      tick();
      chk("l2_data_00", data2, 32'h0000_001F);
      chk("l2_valid_00", {31'd0, valid2}, 32'h1);
      set_xy(2, 0);
      tick();
      chk("l2_data_10", data2, 32'h0000_0001);
      chk("l2_valid_10", {31'd0, valid2}, 32'h1);
      set_xy(3, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid2", {31'd0, valid2}, 32'h0);
      chk("ar_data2", data2, 32'h0);
      chk("ar_valid0", {31'd0, valid0}, 32'h0);
      tick();
      rst_n = 1'b1;
      set_xy(0, 0);
      chk("ar_en_00", {31'd0, en2}, 32'h1);
      tick();
      chk("ar_valid_1cyc", {31'd0, valid2}, 32'h0);
      set_xy(1, 0);
      tick();
      chk("ar_valid_2cyc", {31'd0, valid2}, 32'h1);
      chk("ar_data_2cyc", data2, 32'h0000_001F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
